// File: rtl/mul_fp52_pkg.sv
// Shared constants and types for the mul_fp52_mac fused multiply-add.
//   DAT_W  : mantissa width (fixed at 6)
//   EXP_W  : exponent width (fixed at 2, range 0..3)
//   RES_W  : result width; holds 63*8*63*8 + 63*8 = 254520
//   PP_W   : Booth partial-product width, a shifted by one plus a sign bit
//   booth_dig_t / booth_enc : radix-4 Booth digit as {neg, one, two}
package mul_fp52_pkg;

  localparam int DAT_W  = 6;
  localparam int EXP_W  = 2;
  localparam int RES_W  = 18;
  localparam int PP_W   = DAT_W + 2;
  localparam int PROD_W = 2 * DAT_W;
  // b zero-extended to DAT_W+2 bits gives this many radix-4 digits
  localparam int NDIG   = (DAT_W + 2) / 2;

  typedef struct packed {
    logic neg;  // digit is negative
    logic one;  // magnitude 1
    logic two;  // magnitude 2
  } booth_dig_t;

  // Encode one overlapping triplet {b[2i+1], b[2i], b[2i-1]}.
  // 000 and 111 both encode zero; 111 comes out as "-0", which the
  // invert-plus-one correction turns back into zero.
  function automatic booth_dig_t booth_enc(input logic [2:0] trip);
    booth_dig_t d;
    d.neg = trip[2];
    d.one = trip[1] ^ trip[0];
    d.two = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
    return d;
  endfunction

endpackage

// File: rtl/mbe_mul_6x6_unsign.sv
// Purely combinational 6x6 unsigned radix-4 Modified Booth multiplier.
// Ports:
//   a    in  6   multiplicand, unsigned
//   b    in  6   multiplier, unsigned (zero-extended to 8 bits before recoding)
//   prod out 12  exact unsigned product a*b
module mbe_mul_6x6_unsign
  import mul_fp52_pkg::*;
(
  input  logic [DAT_W-1:0]  a,
  input  logic [DAT_W-1:0]  b,
  output logic [PROD_W-1:0] prod
);

  // {0, 0, b, 0}: two zero bits on top keep the recoding unsigned,
  // the appended zero is the implicit b[-1] of the first triplet.
  logic [PP_W:0] b_ext;
  assign b_ext = {2'b00, b, 1'b0};

  logic [PROD_W-1:0] pp [NDIG];

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_pp
      booth_dig_t        dig;
      logic [PP_W-2:0]   mag;
      logic [PP_W-1:0]   pp_raw;
      logic [PROD_W-1:0] pp_ext;

      assign dig    = booth_enc(b_ext[2*gi+2 : 2*gi]);
      assign mag    = dig.two ? {a, 1'b0} : (dig.one ? {1'b0, a} : '0);
      // Negation is invert here plus the +1 added at this digit's LSB below.
      assign pp_raw = dig.neg ? ~{1'b0, mag} : {1'b0, mag};
      // Sign-extend to product width; the sum is taken modulo 2^12, which is
      // exact because the true product always fits in 12 bits.
      assign pp_ext = {{(PROD_W-PP_W){pp_raw[PP_W-1]}}, pp_raw} + PROD_W'(dig.neg);
      assign pp[gi] = pp_ext << (2 * gi);
    end
  endgenerate

  always_comb begin
    prod = '0;
    for (int i = 0; i < NDIG; i++) begin
      prod = prod + pp[i];
    end
  end

endmodule

// File: rtl/mul_fp52_mac.sv
// Tiny unsigned fused multiply-add:
//   res = ((a*b) << (ea+eb)) + (c << ec), exact, un-normalised, registered.
// Ports:
//   clk       in  1   rising-edge clock
//   rst_n     in  1   asynchronous reset, active low; clears every register
//   op_a_dat  in  6   mantissa a        op_a_exp in 2  exponent of a
//   op_b_dat  in  6   mantissa b        op_b_exp in 2  exponent of b
//   op_c_dat  in  6   addend mantissa c op_c_exp in 2  exponent of c
//   res       out 18  registered result
// Build option MUL_FP52_PIPE_EN:
//   defined   - inputs registered, then res registered (latency 2)
//   undefined - inputs feed the datapath directly, only res registered (latency 1)
module mul_fp52_mac
  import mul_fp52_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DAT_W-1:0] op_a_dat,
  input  logic [DAT_W-1:0] op_b_dat,
  input  logic [DAT_W-1:0] op_c_dat,
  input  logic [EXP_W-1:0] op_a_exp,
  input  logic [EXP_W-1:0] op_b_exp,
  input  logic [EXP_W-1:0] op_c_exp,
  output logic [RES_W-1:0] res
);

  // Operands as seen by the arithmetic stage
  logic [DAT_W-1:0] a_s, b_s, c_s;
  logic [EXP_W-1:0] ea_s, eb_s, ec_s;

`ifdef MUL_FP52_PIPE_EN
  logic [DAT_W-1:0] a_d, b_d, c_d, a_q, b_q, c_q;
  logic [EXP_W-1:0] ea_d, eb_d, ec_d, ea_q, eb_q, ec_q;

  always_comb begin
    a_d  = op_a_dat;
    b_d  = op_b_dat;
    c_d  = op_c_dat;
    ea_d = op_a_exp;
    eb_d = op_b_exp;
    ec_d = op_c_exp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      ea_q <= '0;
      eb_q <= '0;
      ec_q <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      c_q  <= c_d;
      ea_q <= ea_d;
      eb_q <= eb_d;
      ec_q <= ec_d;
    end
  end

  assign a_s  = a_q;
  assign b_s  = b_q;
  assign c_s  = c_q;
  assign ea_s = ea_q;
  assign eb_s = eb_q;
  assign ec_s = ec_q;
`else
  assign a_s  = op_a_dat;
  assign b_s  = op_b_dat;
  assign c_s  = op_c_dat;
  assign ea_s = op_a_exp;
  assign eb_s = op_b_exp;
  assign ec_s = op_c_exp;
`endif

  logic [PROD_W-1:0] prod;

  mbe_mul_6x6_unsign u_mul (
    .a    (a_s),
    .b    (b_s),
    .prod (prod)
  );

  logic [EXP_W:0]   exp_sum;  // ea+eb spans 0..6, needs one extra bit
  logic [RES_W-1:0] res_d, res_q;

  always_comb begin
    exp_sum = {1'b0, ea_s} + {1'b0, eb_s};
    // Largest terms: 3969<<6 and 63<<3; their sum 254520 fits in RES_W bits.
    res_d   = (RES_W'(prod) << exp_sum) + (RES_W'(c_s) << ec_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: tb/tb_mul_fp52_mac.sv
// Self-checking bench for mul_fp52_mac. Expected values come from plain
// integer arithmetic of the fused multiply-add formula. Latency follows the
// MUL_FP52_PIPE_EN build option.
module tb_mul_fp52_mac;

`ifdef MUL_FP52_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  op_a_dat = '0, op_b_dat = '0, op_c_dat = '0;
  logic [1:0]  op_a_exp = '0, op_b_exp = '0, op_c_exp = '0;
  logic [17:0] res;

  int n_vec = 0;
  int n_err = 0;

  mul_fp52_mac dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_a_dat (op_a_dat),
    .op_b_dat (op_b_dat),
    .op_c_dat (op_c_dat),
    .op_a_exp (op_a_exp),
    .op_b_exp (op_b_exp),
    .op_c_exp (op_c_exp),
    .res      (res)
  );

  always #5 clk = ~clk;

  function automatic int unsigned model(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned ea,
                                        input int unsigned eb, input int unsigned ec);
    return (a * b) * (1 << (ea + eb)) + c * (1 << ec);
  endfunction

  task automatic drive(input int unsigned a, input int unsigned b, input int unsigned c,
                       input int unsigned ea, input int unsigned eb, input int unsigned ec);
    op_a_dat = 6'(a);
    op_b_dat = 6'(b);
    op_c_dat = 6'(c);
    op_a_exp = 2'(ea);
    op_b_exp = 2'(eb);
    op_c_exp = 2'(ec);
  endtask

  task automatic test_reset;
    int unsigned exp_v;
    drive($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    #2;
    n_vec++;
    if (res !== 18'd0) begin
      n_err++;
      $display("FAIL reset_async: res=%0d expected 0", res);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (res !== 18'd0) begin
      n_err++;
      $display("FAIL reset_held: res=%0d expected 0", res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(3, 5, 0, 0, 0, 0);
    exp_v = model(3, 5, 0, 0, 0, 0);
    repeat (LAT) @(posedge clk);
    #1;
    n_vec++;
    $display("reset_release: res=%0d expected %0d", res, exp_v);
    if (res !== 18'(exp_v)) begin
      n_err++;
      $display("FAIL reset_release: res=%0d expected %0d", res, exp_v);
    end
  endtask

  task automatic test_corners;
    int unsigned va [4] = '{63, 0, 63, 17};
    int unsigned vb [4] = '{63, 0, 0, 45};
    int unsigned vc [4] = '{63, 63, 63, 0};
    int unsigned ve [4] = '{3, 3, 3, 3};
    int unsigned exp_v;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(va[i], vb[i], vc[i], ve[i], ve[i], ve[i]);
      exp_v = model(va[i], vb[i], vc[i], ve[i], ve[i], ve[i]);
      repeat (LAT) @(posedge clk);
      #1;
      n_vec++;
      $display("corner %0d: a=%0d b=%0d c=%0d res=%0d expected %0d",
               i, va[i], vb[i], vc[i], res, exp_v);
      if (res !== 18'(exp_v)) begin
        n_err++;
        $display("FAIL corner_%0d: res=%0d expected %0d", i, res, exp_v);
      end
    end
  endtask

  task automatic test_booth;
    int unsigned vb [3] = '{42, 21, 63};
    int unsigned want [3] = '{2646, 1323, 3969};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(63, vb[i], 0, 0, 0, 0);
      repeat (LAT) @(posedge clk);
      #1;
      n_vec++;
      $display("booth b=%0d: res=%0d expected %0d", vb[i], res, want[i]);
      if (res !== 18'(want[i])) begin
        n_err++;
        $display("FAIL booth_b%0d: res=%0d expected %0d", vb[i], res, want[i]);
      end
    end
  endtask

  task automatic test_shifts;
    @(negedge clk);
    drive(1, 1, 1, 3, 3, 2);
    repeat (LAT) @(posedge clk);
    #1;
    n_vec++;
    $display("shift_a: res=%0d expected 68", res);
    if (res !== 18'd68) begin
      n_err++;
      $display("FAIL shift_a: res=%0d expected 68", res);
    end
    @(negedge clk);
    drive(5, 7, 9, 2, 1, 1);
    repeat (LAT) @(posedge clk);
    #1;
    n_vec++;
    $display("shift_b: res=%0d expected 298", res);
    if (res !== 18'd298) begin
      n_err++;
      $display("FAIL shift_b: res=%0d expected 298", res);
    end
  endtask

  // All 4096 (a,b) pairs back to back, random c and exponents.
  task automatic test_back_to_back;
    int unsigned exp_q [$];
    int unsigned a, b, c, ea, eb, ec, exp_v;
    for (int i = 0; i < 4096 + LAT; i++) begin
      @(negedge clk);
      if (exp_q.size() == LAT) begin
        exp_v = exp_q.pop_front();
        n_vec++;
        $display("sweep %0d: res=%0d expected %0d", i - LAT, res, exp_v);
        if (res !== 18'(exp_v)) begin
          n_err++;
          $display("FAIL sweep_%0d: res=%0d expected %0d", i - LAT, res, exp_v);
        end
      end
      if (i < 4096) begin
        a  = i / 64;
        b  = i % 64;
        c  = $urandom_range(0, 63);
        ea = $urandom_range(0, 3);
        eb = $urandom_range(0, 3);
        ec = $urandom_range(0, 3);
        drive(a, b, c, ea, eb, ec);
        exp_q.push_back(model(a, b, c, ea, eb, ec));
      end
    end
  endtask

  task automatic test_midstream_reset;
    int unsigned exp_v;
    @(negedge clk);
    drive(7, 9, 3, 1, 2, 1);
    exp_v = model(7, 9, 3, 1, 2, 1);
    repeat (LAT) @(posedge clk);
    #1;
    n_vec++;
    $display("pre_reset: res=%0d expected %0d", res, exp_v);
    if (res !== 18'(exp_v)) begin
      n_err++;
      $display("FAIL pre_reset: res=%0d expected %0d", res, exp_v);
    end
    @(negedge clk);
    drive(50, 60, 40, 3, 2, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    $display("mid_reset: res=%0d expected 0", res);
    if (res !== 18'd0) begin
      n_err++;
      $display("FAIL mid_reset: res=%0d expected 0", res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(11, 13, 5, 0, 1, 3);
    exp_v = model(11, 13, 5, 0, 1, 3);
`ifdef MUL_FP52_PIPE_EN
    @(posedge clk);
    #1;
    n_vec++;
    if (res !== 18'd0) begin
      n_err++;
      $display("FAIL flush: res=%0d expected 0", res);
    end
    @(posedge clk);
`else
    @(posedge clk);
`endif
    #1;
    n_vec++;
    $display("post_reset: res=%0d expected %0d", res, exp_v);
    if (res !== 18'(exp_v)) begin
      n_err++;
      $display("FAIL post_reset: res=%0d expected %0d", res, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_booth();
    test_shifts();
    test_back_to_back();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
